// File: rtl/pipe_hazard_if.sv
// Hazard-controller port bundle: core-side status in, stall/flush/redirect out.
// master = core pipeline side, slave = pipe_hazard_ctrl.
interface pipe_hazard_if #(parameter int REG_AW = 5);
  logic              id_valid, id_fire;
  logic [31:0]       id_pc;
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              id_rs1_en, id_rs2_en, id_serial, id_fencei;
  logic              ex_valid, mem_valid, wb_valid;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_wen, mem_wen, wb_wen;
  logic              ex_is_load, mem_load_pend;
  logic              ex_redirect;
  logic [31:0]       ex_redirect_pc;
  logic              wb_trap;
  logic [31:0]       wb_trap_pc;
  logic              icache_flush_done;
  logic              stall_id, flush_id, flush_ex, flush_mem;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              icache_flush_req, serial_busy, drain_timeout;

  modport master (
    output id_valid, id_fire, id_pc, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
           id_serial, id_fencei, ex_valid, mem_valid, wb_valid, ex_rd, mem_rd,
           wb_rd, ex_wen, mem_wen, wb_wen, ex_is_load, mem_load_pend,
           ex_redirect, ex_redirect_pc, wb_trap, wb_trap_pc, icache_flush_done,
    input  stall_id, flush_id, flush_ex, flush_mem, redirect_valid,
           redirect_pc, icache_flush_req, serial_busy, drain_timeout
  );

  modport slave (
    input  id_valid, id_fire, id_pc, id_rs1, id_rs2, id_rs1_en, id_rs2_en,
           id_serial, id_fencei, ex_valid, mem_valid, wb_valid, ex_rd, mem_rd,
           wb_rd, ex_wen, mem_wen, wb_wen, ex_is_load, mem_load_pend,
           ex_redirect, ex_redirect_pc, wb_trap, wb_trap_pc, icache_flush_done,
    output stall_id, flush_id, flush_ex, flush_mem, redirect_valid,
           redirect_pc, icache_flush_req, serial_busy, drain_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: RAW stalls, trap/redirect kills, serializing drain FSM.
// Define BYPASS_EN when the datapath has full EX/MEM/WB forwarding.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int DRAIN_MAX = 255
) (
  input  logic         clock,
  input  logic         reset,
  pipe_hazard_if.slave bus
);
  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(DRAIN_MAX);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_IFLUSH, S_RESUME} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_timeout, r_abort;

  function automatic logic f_hit(input logic v, input logic wen,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] rs1, input logic rs1_en,
                                 input logic [REG_AW-1:0] rs2, input logic rs2_en);
    return v & wen & (rd != '0) & ((rs1_en & (rs1 == rd)) | (rs2_en & (rs2 == rd)));
  endfunction

  logic w_hit_ex, w_hit_mem, w_raw;
  assign w_hit_ex  = f_hit(bus.ex_valid, bus.ex_wen, bus.ex_rd, bus.id_rs1,
                           bus.id_rs1_en, bus.id_rs2, bus.id_rs2_en);
  assign w_hit_mem = f_hit(bus.mem_valid, bus.mem_wen, bus.mem_rd, bus.id_rs1,
                           bus.id_rs1_en, bus.id_rs2, bus.id_rs2_en);

`ifdef BYPASS_EN
  // Forwarding covers everything except data that does not exist yet.
  logic w_unused;
  assign w_unused = &{1'b0, bus.wb_rd, bus.wb_wen};
  assign w_raw = (w_hit_ex & bus.ex_is_load) | (w_hit_mem & bus.mem_load_pend);
`else
  logic w_hit_wb, w_unused;
  assign w_hit_wb = f_hit(bus.wb_valid, bus.wb_wen, bus.wb_rd, bus.id_rs1,
                          bus.id_rs1_en, bus.id_rs2, bus.id_rs2_en);
  assign w_unused = &{1'b0, bus.ex_is_load, bus.mem_load_pend};
  assign w_raw = w_hit_ex | w_hit_mem | w_hit_wb;
`endif

  logic w_kill, w_enter, w_empty, w_resume_fi;
  logic [CW-1:0] w_cnt_inc;
  assign w_kill      = bus.wb_trap | bus.ex_redirect;
  assign w_enter     = (r_state == S_IDLE) & bus.id_valid & bus.id_serial & ~w_kill;
  assign w_empty     = ~bus.ex_valid & ~bus.mem_valid & ~bus.wb_valid;
  assign w_resume_fi = (r_state == S_RESUME) & bus.id_fire & bus.id_fencei & ~w_kill;
  assign w_cnt_inc   = (r_cnt == CMAX) ? r_cnt : r_cnt + CW'(1);

  assign bus.flush_ex       = bus.wb_trap;
  assign bus.flush_mem      = bus.wb_trap;
  assign bus.flush_id       = w_kill | w_resume_fi;
  assign bus.redirect_valid = w_kill | w_resume_fi;
  // fence.i re-fetches its successor: anything fetched before the invalidate is stale.
  assign bus.redirect_pc    = bus.wb_trap     ? bus.wb_trap_pc     :
                              bus.ex_redirect ? bus.ex_redirect_pc :
                              w_resume_fi     ? bus.id_pc + 32'd4  : 32'd0;
  assign bus.stall_id       = ~w_kill & ((r_state == S_DRAIN) | (r_state == S_IFLUSH) |
                                         w_enter | ((r_state == S_IDLE) & w_raw));
  assign bus.icache_flush_req = (r_state == S_IFLUSH);
  assign bus.serial_busy      = (r_state != S_IDLE);
  assign bus.drain_timeout    = r_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_enter) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_kill) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_empty) begin
            r_state <= bus.id_fencei ? S_IFLUSH : S_RESUME;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CMAX) r_timeout <= 1'b1;
          end
        end
        // The I$ request cannot be withdrawn, so a kill here only marks the abort.
        S_IFLUSH: begin
          if (bus.icache_flush_done) begin
            r_state <= (r_abort | w_kill) ? S_IDLE : S_RESUME;
            r_abort <= 1'b0;
          end else if (w_kill) begin
            r_abort <= 1'b1;
          end
        end
        S_RESUME: begin
          if (w_kill | bus.id_fire) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
